// File: rtl/sine_mon_pkg.sv
// Shared types and default parameters for the sine-wave monitor.
package sine_mon_pkg;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } mon_state_t;

    localparam int DATA_W     = 16;
    localparam int CNT_W      = 16;
    localparam int HYST       = 256;
    localparam int MAX_PERIOD = 4095;

endpackage

// File: rtl/sine_zero_cross_det.sv
// Rising zero-crossing detector with hysteresis: arms below -HYST and
// strobes (combinationally) on the first non-negative valid sample after.
module sine_zero_cross_det #(
    parameter int DATA_W = sine_mon_pkg::DATA_W,
    parameter int HYST   = sine_mon_pkg::HYST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              clr,
    output logic              xing
);
    import sine_mon_pkg::*;

    localparam logic signed [DATA_W-1:0] ARM_LVL = DATA_W'(-HYST);

    logic r_armed;
    logic w_below;

    assign w_below = $signed(sample_in) < ARM_LVL;
    assign xing    = sample_valid && r_armed && !sample_in[DATA_W-1];

    // Armed flag: set below -HYST, cleared by the crossing or by a timeout;
    // samples in [-HYST,-1] leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (clr) begin
            r_armed <= 1'b0;
        end else if (sample_valid) begin
            if (w_below)
                r_armed <= 1'b1;
            else if (xing)
                r_armed <= 1'b0;
        end
    end

endmodule

// File: rtl/sine_wave_monitor.sv
// Period / amplitude checker for the IIR sine oscillator output.
// Periods are measured in valid samples between rising zero crossings;
// the crossing sample opens the new period.
module sine_wave_monitor #(
    parameter int DATA_W     = sine_mon_pkg::DATA_W,
    parameter int CNT_W      = sine_mon_pkg::CNT_W,
    parameter int HYST       = sine_mon_pkg::HYST,
    parameter int MAX_PERIOD = sine_mon_pkg::MAX_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [CNT_W-1:0]  period_out,
    output logic [DATA_W-1:0] amp_max,
    output logic [DATA_W-1:0] amp_min,
    output logic [DATA_W:0]   pp_out,
    output logic              result_valid,
    output logic              timeout,
    output logic              locked
);
    import sine_mon_pkg::*;

    mon_state_t               r_state;
    logic [CNT_W-1:0]         r_count;
    logic signed [DATA_W-1:0] r_run_max;
    logic signed [DATA_W-1:0] r_run_min;

    logic signed [DATA_W-1:0] w_s;
    logic                     w_xing;
    logic                     w_at_limit;
    logic                     w_tmo;
    logic [DATA_W:0]          w_pp;

    assign w_s        = sample_in;
    assign w_at_limit = (r_count == CNT_W'(MAX_PERIOD));
    // A crossing on the limit sample takes priority over the timeout.
    assign w_tmo      = sample_valid && (r_state == MEASURE) && !w_xing && w_at_limit;
    assign w_pp       = {r_run_max[DATA_W-1], r_run_max} - {r_run_min[DATA_W-1], r_run_min};

    sine_zero_cross_det #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_xdet (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clr          (w_tmo),
        .xing         (w_xing)
    );

    // FSM, period counter, running extremes and published results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SEARCH;
            r_count      <= '0;
            r_run_max    <= '0;
            r_run_min    <= '0;
            period_out   <= '0;
            amp_max      <= '0;
            amp_min      <= '0;
            pp_out       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (sample_valid) begin
                if (w_xing) begin
                    if (r_state == MEASURE) begin
                        period_out   <= r_count;
                        amp_max      <= r_run_max;
                        amp_min      <= r_run_min;
                        pp_out       <= w_pp;
                        result_valid <= 1'b1;
                        locked       <= 1'b1;
                    end
                    r_state   <= MEASURE;
                    r_count   <= CNT_W'(1);
                    r_run_max <= w_s;
                    r_run_min <= w_s;
                end else if (r_state == MEASURE) begin
                    if (w_at_limit) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        r_state <= SEARCH;
                    end else begin
                        r_count <= r_count + 1'b1;
                        if (w_s > r_run_max) r_run_max <= w_s;
                        if (w_s < r_run_min) r_run_min <= w_s;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_wave_monitor.sv
// Self-checking bench for sine_wave_monitor against a queue-based period model.
module tb_sine_wave_monitor;
    localparam int HYST  = 256;
    localparam int MAX_P = 4095;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] period_out;
    logic [15:0] amp_max;
    logic [15:0] amp_min;
    logic [16:0] pp_out;
    logic        result_valid;
    logic        timeout;
    logic        locked;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sine_wave_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .period_out   (period_out),
        .amp_max      (amp_max),
        .amp_min      (amp_min),
        .pp_out       (pp_out),
        .result_valid (result_valid),
        .timeout      (timeout),
        .locked       (locked)
    );

    // Reference model: the current period is kept as a list of its samples.
    bit          m_armed;
    bit          m_meas;
    int          m_q[$];
    logic [15:0] e_period, e_max, e_min;
    logic [16:0] e_pp;
    logic        e_rv, e_to, e_lock;

    task automatic model_reset();
        m_armed = 0; m_meas = 0; m_q.delete();
        e_period = '0; e_max = '0; e_min = '0; e_pp = '0;
        e_rv = 0; e_to = 0; e_lock = 0;
    endtask

    task automatic model_step(input int s, input bit v);
        bit x;
        int mx, mn;
        e_rv = 0; e_to = 0;
        if (!v) return;
        x = m_armed && (s >= 0);
        if (x) begin
            if (m_meas) begin
                mx = m_q[0]; mn = m_q[0];
                foreach (m_q[i]) begin
                    if (m_q[i] > mx) mx = m_q[i];
                    if (m_q[i] < mn) mn = m_q[i];
                end
                e_period = 16'(m_q.size());
                e_max = 16'(mx); e_min = 16'(mn); e_pp = 17'(mx - mn);
                e_rv = 1; e_lock = 1;
            end
            m_q.delete(); m_q.push_back(s);
            m_meas = 1; m_armed = 0;
        end else if (m_meas && m_q.size() == MAX_P) begin
            e_to = 1; e_lock = 0; m_meas = 0; m_q.delete(); m_armed = 0;
        end else begin
            if (m_meas) m_q.push_back(s);
            if (s < -HYST) m_armed = 1;
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input int s, input bit v);
        @(negedge clk);
        sample_in = 16'(s);
        sample_valid = v;
        @(posedge clk);
        model_step(s, v);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Symmetric triangle, +/-8000, starting at 0 rising.
    function automatic int tri_val(input int i, input int per);
        int q, st, p;
        q = per / 4; st = 8000 / q; p = i % per;
        if (p <= q)          return st * p;
        else if (p <= 3 * q) return 8000 - st * (p - q);
        else                 return -8000 + st * (p - 3 * q);
    endfunction

    task automatic test_reset();
        int rv_seen;
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got %h want 0", {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked});
        end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 80; i++) drive(tri_val(i, 32), 1'b1);
        n_tests++;
        if (locked !== 1'b1 || period_out !== 16'd32) begin
            n_fail++;
            $display("FAIL reset_prelock: locked=%b period=%0d want 1/32", locked, period_out);
        end
        // Assert reset between edges and observe the asynchronous clear.
        @(negedge clk); #2; reset = 1'b1; sample_valid = 1'b0; #1;
        model_reset();
        n_tests++;
        if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked});
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want 0", {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked});
        end
        @(negedge clk); reset = 1'b0;
        // Resume mid-period: crossing at i=22 only restarts measurement.
        rv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            drive(tri_val(i + 10, 32), 1'b1);
            if (result_valid) rv_seen++;
            n_tests++;
            if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !==
                {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock}) begin
                n_fail++;
                $display("FAIL reset_resume i=%0d: got %h want %h", i,
                    {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked},
                    {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock});
            end
        end
        n_tests++;
        if (rv_seen !== 0) begin
            n_fail++;
            $display("FAIL reset_first_xing: result_valid count %0d want 0", rv_seen);
        end
    endtask

    task automatic test_triangle32();
        int rv_seen;
        logic l63, l64;
        do_reset();
        rv_seen = 0; l63 = 1'bx; l64 = 1'bx;
        for (int i = 0; i < 192; i++) begin
            drive(tri_val(i, 32), 1'b1);
            if (result_valid) rv_seen++;
            if (i == 63) l63 = locked;
            if (i == 64) l64 = locked;
            n_tests++;
            if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !==
                {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock}) begin
                n_fail++;
                $display("FAIL tri32 i=%0d: got %h want %h", i,
                    {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked},
                    {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock});
            end
        end
        n_tests++;
        if (rv_seen !== 4 || l63 !== 1'b0 || l64 !== 1'b1) begin
            n_fail++;
            $display("FAIL tri32_lock: rv=%0d lock63=%b lock64=%b want 4/0/1", rv_seen, l63, l64);
        end
        n_tests++;
        if (period_out !== 16'd32 || amp_max !== 16'(8000) || amp_min !== 16'(-8000) || pp_out !== 17'd16000) begin
            n_fail++;
            $display("FAIL tri32_values: per=%0d max=%h min=%h pp=%0d want 32/1f40/e0c0/16000",
                period_out, amp_max, amp_min, pp_out);
        end
    endtask

    task automatic test_noise();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            drive((i % 2) ? 100 : -100, 1'b1);
            if (result_valid || timeout || locked) bad++;
        end
        n_tests++;
        if (bad !== 0 || e_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL noise: %0d cycles with rv/timeout/locked high, want 0", bad);
        end
    endtask

    task automatic test_timeout();
        int to_at, rv_at;
        do_reset();
        for (int i = 0; i < 96; i++) drive(tri_val(i, 32), 1'b1);
        to_at = -1; rv_at = -1;
        for (int k = 0; k < 4100; k++) begin
            drive(0, 1'b1);
            if (timeout && to_at < 0) to_at = k;
            if (result_valid && rv_at < 0) rv_at = k;
            n_tests++;
            if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !==
                {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock}) begin
                n_fail++;
                $display("FAIL timeout_run k=%0d: got %h want %h", k,
                    {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked},
                    {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock});
            end
        end
        n_tests++;
        if (to_at !== 4095 || rv_at !== 0) begin
            n_fail++;
            $display("FAIL timeout_pos: timeout at %0d rv at %0d want 4095/0", to_at, rv_at);
        end
        n_tests++;
        if (locked !== 1'b0 || period_out !== 16'd32 || amp_max !== 16'(8000) || pp_out !== 17'd16000) begin
            n_fail++;
            $display("FAIL timeout_hold: locked=%b per=%0d max=%h pp=%0d want 0/32/1f40/16000",
                locked, period_out, amp_max, pp_out);
        end
    endtask

    task automatic test_gapped();
        int vi, rv_seen;
        do_reset();
        vi = 0; rv_seen = 0;
        for (int c = 0; c < 288; c++) begin
            if (c % 3 == 2) begin
                drive(tri_val(vi, 16), 1'b1);
                vi++;
            end else begin
                drive(int'($urandom_range(0, 20000)) - 10000, 1'b0);
            end
            if (result_valid) rv_seen++;
            n_tests++;
            if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !==
                {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock}) begin
                n_fail++;
                $display("FAIL gapped c=%0d: got %h want %h", c,
                    {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked},
                    {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock});
            end
        end
        n_tests++;
        if (rv_seen !== 4 || period_out !== 16'd16 || amp_max !== 16'(8000) ||
            amp_min !== 16'(-8000) || pp_out !== 17'd16000) begin
            n_fail++;
            $display("FAIL gapped_values: rv=%0d per=%0d max=%h min=%h pp=%0d want 4/16/1f40/e0c0/16000",
                rv_seen, period_out, amp_max, amp_min, pp_out);
        end
    endtask

    task automatic test_max_period();
        do_reset();
        drive(-1000, 1'b1);
        drive(0, 1'b1);
        for (int i = 0; i < 4000; i++) drive(100, 1'b1);
        for (int i = 0; i < 94; i++) drive(-1000, 1'b1);
        drive(0, 1'b1);
        n_tests++;
        if (result_valid !== 1'b1 || timeout !== 1'b0 || period_out !== 16'd4095 ||
            amp_max !== 16'd100 || amp_min !== 16'(-1000) || pp_out !== 17'd1100) begin
            n_fail++;
            $display("FAIL max_period: rv=%b to=%b per=%0d max=%h min=%h pp=%0d want 1/0/4095/0064/fc18/1100",
                result_valid, timeout, period_out, amp_max, amp_min, pp_out);
        end
    endtask

    task automatic test_random();
        int s;
        bit v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) s = int'($urandom_range(0, 20000)) - 10000;
            else                           s = int'($urandom_range(0, 800)) - 400;
            drive(s, v);
            n_tests++;
            if ({period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked} !==
                {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock}) begin
                n_fail++;
                $display("FAIL random i=%0d: got %h want %h", i,
                    {period_out, amp_max, amp_min, pp_out, result_valid, timeout, locked},
                    {e_period, e_max, e_min, e_pp, e_rv, e_to, e_lock});
            end
        end
    endtask

    initial begin
        reset = 1'b1; sample_in = '0; sample_valid = 1'b0;
        test_reset();
        test_triangle32();
        test_noise();
        test_timeout();
        test_gapped();
        test_max_period();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
